// File: rtl/apb_master_bridge.sv
// ----------------------------------------------------------------------------
// apb_master_bridge
//
// Purpose:
//   Converts single read/write commands from a valid/ready request port into
//   APB4 SETUP/ACCESS transfers. The top two address bits select one of up to
//   four slave regions (one-hot PSEL). Regions at or above NUM_SLAVES are
//   unmapped. Those commands are answered with an error and never reach the
//   bus. A PREADY wait-state timeout aborts transfers to a hung slave.
//   Every response is a one-cycle rsp_valid strobe with data/error.
//
// Ports:
//   PCLK, PRESET          clock (rising edge) / async active-high reset
//   req_valid/req_ready   command handshake (accepted when both high)
//   req_write             1 = write, 0 = read
//   req_addr/wdata/strb/prot  command payload, held stable until accepted
//   rsp_valid             one-cycle response strobe (no backpressure)
//   rsp_rdata/rsp_err     read data (0 on write/error) and error flag
//   PSEL..PPROT           APB4 requester outputs (all registered)
//   PRDATA/PREADY/PSLVERR APB4 completer inputs
// ----------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // request port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_strb,
  input  logic [2:0]            req_prot,
  // response port
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // APB4 requester
  output logic [3:0]            PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [3:0]            PSTRB,
  output logic [2:0]            PPROT,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit so the
  // declaration stays legal when the timeout is disabled or equals 1.
  localparam int             CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]     NS       = 3'(NUM_SLAVES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t r_state, w_state_n;

  logic [CW-1:0]         r_cnt,       w_cnt_n;
  logic                  r_req_ready, w_req_ready_n;
  logic [3:0]            r_psel,      w_psel_n;
  logic                  r_penable,   w_penable_n;
  logic                  r_pwrite,    w_pwrite_n;
  logic [ADDR_WIDTH-1:0] r_paddr,     w_paddr_n;
  logic [DATA_WIDTH-1:0] r_pwdata,    w_pwdata_n;
  logic [3:0]            r_pstrb,     w_pstrb_n;
  logic [2:0]            r_pprot,     w_pprot_n;
  logic                  r_rsp_valid, w_rsp_valid_n;
  logic                  r_rsp_err,   w_rsp_err_n;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_n;

  logic       w_hs;
  logic [1:0] w_region;
  logic       w_mapped;
  logic       w_done;
  logic       w_tmo;

  // r_req_ready is only high in IDLE, so the handshake needs no state term.
  assign w_hs     = req_valid & r_req_ready;
  assign w_region = req_addr[ADDR_WIDTH-1 -: 2];
  assign w_mapped = ({1'b0, w_region} < NS);
  assign w_done   = (r_state == ST_ACCESS) & PREADY;
  // Abort on the ACCESS cycle that would be the TIMEOUT_CYCLES-th with PREADY
  // low; a PREADY arriving on that same cycle still completes normally.
  assign w_tmo    = (r_state == ST_ACCESS) & ~PREADY &
                    (TIMEOUT_CYCLES != 0) & (r_cnt == TMO_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= ST_IDLE;
    else        r_state <= w_state_n;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE:   if (w_hs && w_mapped) w_state_n = ST_SETUP;
      ST_SETUP:  w_state_n = ST_ACCESS;
      ST_ACCESS: if (w_done || w_tmo) w_state_n = ST_IDLE;
      default:   w_state_n = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: next values for all registered outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_cnt_n       = r_cnt;
    w_req_ready_n = (w_state_n == ST_IDLE);
    w_psel_n      = r_psel;
    w_penable_n   = r_penable;
    w_pwrite_n    = r_pwrite;
    w_paddr_n     = r_paddr;
    w_pwdata_n    = r_pwdata;
    w_pstrb_n     = r_pstrb;
    w_pprot_n     = r_pprot;
    w_rsp_valid_n = 1'b0;
    w_rsp_err_n   = r_rsp_err;
    w_rsp_rdata_n = r_rsp_rdata;

    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          if (w_mapped) begin
            // The APB registers double as the command latch; loading them at
            // accept makes SETUP show the command on the very next cycle.
            w_psel_n    = 4'(4'b0001 << w_region);
            w_penable_n = 1'b0;
            w_pwrite_n  = req_write;
            w_paddr_n   = req_addr;
            w_pwdata_n  = req_wdata;
            w_pstrb_n   = req_write ? req_strb : 4'b0000;
            w_pprot_n   = req_prot;
            w_cnt_n     = '0;
          end else begin
            // Unmapped region: answer immediately, bus untouched.
            w_rsp_valid_n = 1'b1;
            w_rsp_err_n   = 1'b1;
            w_rsp_rdata_n = '0;
          end
        end
      end

      ST_SETUP: begin
        w_penable_n = 1'b1;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          w_psel_n      = 4'b0000;
          w_penable_n   = 1'b0;
          w_rsp_valid_n = 1'b1;
          w_rsp_err_n   = PSLVERR;
          w_rsp_rdata_n = (!r_pwrite && !PSLVERR) ? PRDATA : '0;
        end else if (w_tmo) begin
          w_psel_n      = 4'b0000;
          w_penable_n   = 1'b0;
          w_rsp_valid_n = 1'b1;
          w_rsp_err_n   = 1'b1;
          w_rsp_rdata_n = '0;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end

      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_psel      <= 4'b0000;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= 4'b0000;
      r_pprot     <= 3'b000;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_cnt       <= w_cnt_n;
      r_req_ready <= w_req_ready_n;
      r_psel      <= w_psel_n;
      r_penable   <= w_penable_n;
      r_pwrite    <= w_pwrite_n;
      r_paddr     <= w_paddr_n;
      r_pwdata    <= w_pwdata_n;
      r_pstrb     <= w_pstrb_n;
      r_pprot     <= w_pprot_n;
      r_rsp_valid <= w_rsp_valid_n;
      r_rsp_err   <= w_rsp_err_n;
      r_rsp_rdata <= w_rsp_rdata_n;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;
  assign PPROT     = r_pprot;

endmodule

// File: tb/tb_apb_master_bridge.sv
// ----------------------------------------------------------------------------
// tb_apb_master_bridge
//
// DUT built with NUM_SLAVES=2 (regions 2/3 unmapped) and TIMEOUT_CYCLES=4.
// The bench plays both the requester and a scripted APB slave. Expected
// responses come from a transaction-level model: latency, error and data
// per command.
// ----------------------------------------------------------------------------
module tb_apb_master_bridge;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int NS  = 2;
  localparam int TMO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_strb;
  logic [2:0]    req_prot;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [3:0]    PSEL, PSTRB;
  logic          PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic [2:0]    PPROT;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Transaction-level reference: cycles from accept edge to response,
  // response error and response data.
  function automatic void model(input logic w, input logic [AW-1:0] addr,
                                input int waits, input logic slverr,
                                input logic [DW-1:0] rdata, output int lat,
                                output logic err, output logic [DW-1:0] data);
    int rg;
    rg = int'(addr[AW-1 -: 2]);
    if (rg >= NS) begin
      lat = 1; err = 1'b1; data = '0;
    end else if (waits >= TMO) begin
      lat = 2 + TMO; err = 1'b1; data = '0;
    end else begin
      lat = 3 + waits; err = slverr; data = (w || slverr) ? '0 : rdata;
    end
  endfunction

  // One command: must be called at a negedge with the DUT idle. Returns at
  // the negedge of cycle lat+gap after the accept edge.
  task automatic xfer(input string nm, input logic w, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [3:0] strb,
                      input logic [2:0] prot, input int waits, input logic slverr,
                      input logic [DW-1:0] rdata, input int gap);
    int            lat;
    logic          eerr, early, mapped;
    logic [DW-1:0] edata;
    logic [3:0]    epsel;
    logic [1:0]    rg;
    rg     = addr[AW-1 -: 2];
    mapped = (int'(rg) < NS);
    epsel  = mapped ? (4'b0001 << rg) : 4'b0000;
    model(w, addr, waits, slverr, rdata, lat, eerr, edata);
    early  = 1'b0;

    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before got %b want 1", nm, req_ready);
    end
    req_valid = 1'b1; req_write = w; req_addr = addr; req_wdata = wdata;
    req_strb = strb; req_prot = prot;

    for (int c = 1; c <= lat + gap; c++) begin
      @(negedge PCLK);
      if (c == 1) begin
        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
      end
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
      if (c < lat && rsp_valid !== 1'b0) early = 1'b1;

      if (c == 1 && mapped) begin
        checks += 8;
        if (PSEL !== epsel) begin errors++; $display("FAIL %s setup_psel got %b want %b", nm, PSEL, epsel); end
        if (PENABLE !== 1'b0) begin errors++; $display("FAIL %s setup_penable got %b want 0", nm, PENABLE); end
        if (PADDR !== addr) begin errors++; $display("FAIL %s paddr got %h want %h", nm, PADDR, addr); end
        if (PWRITE !== w) begin errors++; $display("FAIL %s pwrite got %b want %b", nm, PWRITE, w); end
        if (PWDATA !== wdata) begin errors++; $display("FAIL %s pwdata got %h want %h", nm, PWDATA, wdata); end
        if (PSTRB !== (w ? strb : 4'b0000)) begin errors++; $display("FAIL %s pstrb got %h want %h", nm, PSTRB, (w ? strb : 4'b0000)); end
        if (PPROT !== prot) begin errors++; $display("FAIL %s pprot got %h want %h", nm, PPROT, prot); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL %s busy_ready got %b want 0", nm, req_ready); end
      end
      if (c == 2 && mapped) begin
        checks += 2;
        if (PENABLE !== 1'b1) begin errors++; $display("FAIL %s access_penable got %b want 1", nm, PENABLE); end
        if (PSEL !== epsel) begin errors++; $display("FAIL %s access_psel got %b want %b", nm, PSEL, epsel); end
      end
      if (c == lat) begin
        checks += 6;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL %s rsp_valid got %b want 1", nm, rsp_valid); end
        if (rsp_err !== eerr) begin errors++; $display("FAIL %s rsp_err got %b want %b", nm, rsp_err, eerr); end
        if (rsp_rdata !== edata) begin errors++; $display("FAIL %s rsp_rdata got %h want %h", nm, rsp_rdata, edata); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL %s rsp_ready got %b want 1", nm, req_ready); end
        if (PSEL !== 4'b0000) begin errors++; $display("FAIL %s end_psel got %b want 0000", nm, PSEL); end
        if (PENABLE !== 1'b0) begin errors++; $display("FAIL %s end_penable got %b want 0", nm, PENABLE); end
      end
      if (c == lat + 1) begin
        checks += 3;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s strobe_len got %b want 0", nm, rsp_valid); end
        if (rsp_err !== eerr) begin errors++; $display("FAIL %s err_hold got %b want %b", nm, rsp_err, eerr); end
        if (rsp_rdata !== edata) begin errors++; $display("FAIL %s rdata_hold got %h want %h", nm, rsp_rdata, edata); end
      end
      // Scripted slave: PREADY after 'waits' low ACCESS cycles.
      if (mapped && c == 2 + waits && c < lat) begin
        PREADY = 1'b1; PSLVERR = slverr; PRDATA = rdata;
      end
    end
    checks++;
    if (early !== 1'b0) begin
      errors++; $display("FAIL %s early_rsp got %b want 0", nm, early);
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; req_prot = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    repeat (3) @(negedge PCLK);
    checks += 11;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b want 0", rsp_err); end
    if (rsp_rdata !== '0) begin errors++; $display("FAIL rst_rsp_rdata got %h want 0", rsp_rdata); end
    if (PSEL !== 4'b0000) begin errors++; $display("FAIL rst_psel got %b want 0", PSEL); end
    if (PENABLE !== 1'b0) begin errors++; $display("FAIL rst_penable got %b want 0", PENABLE); end
    if (PWRITE !== 1'b0) begin errors++; $display("FAIL rst_pwrite got %b want 0", PWRITE); end
    if (PADDR !== '0) begin errors++; $display("FAIL rst_paddr got %h want 0", PADDR); end
    if (PWDATA !== '0) begin errors++; $display("FAIL rst_pwdata got %h want 0", PWDATA); end
    if (PSTRB !== 4'b0000) begin errors++; $display("FAIL rst_pstrb got %h want 0", PSTRB); end
    if (PPROT !== 3'b000) begin errors++; $display("FAIL rst_pprot got %h want 0", PPROT); end
    PRESET = 1'b0;
    @(negedge PCLK);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", req_ready); end
  endtask

  task automatic test_write_ram();
    xfer("write_ram", 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b010, 0, 1'b0, 32'h0, 1);
  endtask

  task automatic test_read_uart();
    xfer("read_uart", 1'b0, 16'h4004, 32'h12345678, 4'hF, 3'b000, 2, 1'b0, 32'h000000A5, 1);
  endtask

  task automatic test_slverr();
    xfer("slverr_rd", 1'b0, 16'h0100, 32'h0, 4'h0, 3'b001, 0, 1'b1, 32'hCAFEF00D, 1);
    xfer("slverr_wr", 1'b1, 16'h4200, 32'h55AA55AA, 4'h3, 3'b100, 1, 1'b1, 32'h0, 1);
  endtask

  task automatic test_timeout();
    xfer("timeout", 1'b0, 16'h4008, 32'h0, 4'h0, 3'b000, 50, 1'b0, 32'h11111111, 1);
    xfer("last_wait_ok", 1'b0, 16'h0008, 32'h0, 4'h0, 3'b000, TMO - 1, 1'b0, 32'h22222222, 1);
  endtask

  task automatic test_unmapped();
    xfer("unmapped_c", 1'b0, 16'hC000, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0, 1);
    xfer("unmapped_8", 1'b1, 16'h8FFC, 32'hFFFFFFFF, 4'hF, 3'b111, 0, 1'b0, 32'h0, 1);
  endtask

  task automatic test_back_to_back();
    xfer("b2b_0", 1'b1, 16'h0020, 32'hA0A0A0A0, 4'h5, 3'b000, 0, 1'b0, 32'h0, 0);
    xfer("b2b_1", 1'b0, 16'h4024, 32'h0, 4'h0, 3'b001, 1, 1'b0, 32'h0BADBEEF, 0);
    xfer("b2b_2", 1'b0, 16'hB000, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0, 0);
    xfer("b2b_3", 1'b0, 16'h0030, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h76543210, 1);
  endtask

  task automatic test_reset_mid();
    logic bad;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h4040;
    req_wdata = '0; req_strb = 4'h0; req_prot = 3'b000;
    @(negedge PCLK); req_valid = 1'b0;      // SETUP
    @(negedge PCLK);                        // ACCESS, PREADY low
    checks++;
    if (PENABLE !== 1'b1) begin errors++; $display("FAIL midrst_pre_penable got %b want 1", PENABLE); end
    #2 PRESET = 1'b1;
    #1;
    checks += 4;
    if (PSEL !== 4'b0000) begin errors++; $display("FAIL midrst_psel got %b want 0", PSEL); end
    if (PENABLE !== 1'b0) begin errors++; $display("FAIL midrst_penable got %b want 0", PENABLE); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_rsp got %b want 0", rsp_valid); end
    if (req_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", req_ready); end
    @(negedge PCLK);
    PRESET = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      PREADY = (i < 2);                      // late slave completion must be ignored
      PRDATA = 32'h99999999;
      @(negedge PCLK);
      if (rsp_valid !== 1'b0 || PSEL !== 4'b0000) bad = 1'b1;
    end
    PREADY = 1'b0;
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp got %b want 0", bad); end
    xfer("after_rst", 1'b0, 16'h0044, 32'h0, 4'h0, 3'b000, 1, 1'b0, 32'h13579BDF, 1);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    int            wt;
    for (int n = 0; n < 60; n++) begin
      a  = AW'($urandom);
      wt = ($urandom_range(0, 9) == 0) ? 6 : int'($urandom_range(0, 3));
      xfer("random", 1'($urandom), a, $urandom, 4'($urandom), 3'($urandom),
           wt, ($urandom_range(0, 4) == 0), $urandom, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_write_ram();
    test_read_uart();
    test_slverr();
    test_timeout();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream APB requester for the peripheral subsystem (RAM slave at region 0, UART slave at region 1, regions 2–3 reserved).
- Accepts single read/write commands on a valid/ready request port and converts each into an APB4 SETUP/ACCESS transfer.
- Decodes the top two address bits into the one-hot PSEL[3:0] bus and returns the slave's data/error on a one-cycle response strobe.
- Adds a PREADY wait-state timeout so a hung slave cannot lock the bus.

Parameters:
ADDR_WIDTH, 16, width of req_addr/PADDR; region index = addr[ADDR_WIDTH-1:ADDR_WIDTH-2]
DATA_WIDTH, 32, width of write/read data
NUM_SLAVES, 4, number of populated regions (1..4); regions >= NUM_SLAVES are unmapped
TIMEOUT_CYCLES, 255, max ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESET  in  1  reset, asynchronous, active-high
req_valid  in  1  command valid
req_ready  out  1  command accepted when req_valid && req_ready
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data
req_strb  in  4  write byte enables
req_prot  in  3  protection attribute
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  DATA_WIDTH  read data (0 for writes/errors)
rsp_err  out  1  PSLVERR, timeout, or unmapped region
PSEL  out  4  one-hot slave select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  4  APB byte strobes
PPROT  out  3  APB protection
PRDATA  in  DATA_WIDTH  muxed slave read data
PREADY  in  1  slave ready
PSLVERR  in  1  slave error

Behaviour:
- Reset (PRESET=1, async): state IDLE; all outputs 0 (req_ready=0 while PRESET high, 1 from first cycle after release); timeout counter 0.
- States: IDLE, SETUP, ACCESS. All APB outputs and rsp_* are registered.
- IDLE: req_ready=1. On handshake, latch addr/wdata/strb/prot/write.
  - Region < NUM_SLAVES: go to SETUP.
  - Otherwise: stay IDLE; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; no PSEL asserted.
- SETUP (1 cycle): PSEL[region]=1, PENABLE=0, PADDR/PWRITE/PWDATA/PPROT from latched command; PSTRB=req_strb for writes, 4'b0000 for reads. Next: ACCESS.
- ACCESS: PENABLE=1; all other APB outputs held stable.
  - PREADY=1: capture PRDATA (reads only, else 0) and PSLVERR; PSEL/PENABLE drop to 0; go to IDLE. rsp_valid=1 in the following cycle with rsp_err=PSLVERR.
  - PREADY=0: counter increments each ACCESS cycle.
  - Counter reaching TIMEOUT_CYCLES while PREADY=0 (TIMEOUT_CYCLES>0): abort. Drop PSEL/PENABLE, go to IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - Counter clears on entry to SETUP.
- Latency: accept at edge N -> SETUP cycle N+1 -> ACCESS N+2 -> with zero wait states rsp_valid in cycle N+3, req_ready=1 that same cycle. Back-to-back throughput is 1 transfer per 3 cycles.
- rsp_valid is exactly 1 cycle; there is no response backpressure. rsp_rdata/rsp_err hold until the next response.
- PSEL is never multi-hot. PADDR/PWDATA/PSTRB/PPROT/PWRITE retain their last values in IDLE (not required to zero).
- req_valid while not ready: ignored. Requester holds the command stable until accepted.
- PRESET asserted mid-transfer: immediate return to IDLE, outputs 0, no response emitted for the aborted command.

Test Plan:
- Write to RAM: req_addr=16'h0010, wdata=32'hDEADBEEF, strb=4'hF, PREADY tied 1 -> PSEL=4'b0001 in SETUP, PENABLE high 1 cycle, PSTRB=4'hF, rsp_valid at accept+3, rsp_err=0.
- Read from UART region: req_addr=16'h4004, slave returns PRDATA=32'h000000A5 after 2 wait states -> PSEL=4'b0010, PSTRB=0, rsp_rdata=32'hA5 at accept+5.
- PSLVERR: slave returns PREADY=1, PSLVERR=1 on read -> rsp_err=1, rsp_rdata=0, state IDLE next cycle.
- Timeout: TIMEOUT_CYCLES=4, PREADY held 0 -> PSEL/PENABLE drop after 4 ACCESS cycles, rsp_err=1, req_ready=1.
- Unmapped: NUM_SLAVES=2, req_addr=16'hC000 -> PSEL stays 0, rsp_valid=1 with rsp_err=1 one cycle after accept.
- Reset mid-ACCESS: assert PRESET during wait state -> PSEL/PENABLE/rsp_valid 0 immediately, no response; next request completes normally.
